el_timing_ctrl: RTL and testbench
=================================

// Module: el_timing_ctrl
// PURPOSE
//  Early/late symbol-timing controller at 4x oversampling (clk4 = 4 x symbol rate).
//  - Runs a mod-4 phase counter that schedules the early, prompt and late samples of x_in.
//  - Forms the early-late error |E|-|L| once per symbol and integrates it over NAVG symbols.
//  - Slips the sampling phase one clk4 earlier or later when the integral crosses +/-THRESH.
//  - Sits between the ADC/matched-filter output and the symbol demapper; emits prompt symbols.
// PARAMETERS
//  DW       16    sample width, signed two's complement
//  ACC_W    24    error accumulator / ted_out width, signed
//  NAVG     16    symbols per decision window (legal range 2..2^16)
//  THRESH   1024  decision threshold, positive, < 2^(ACC_W-1)
//  LOCK_CNT 8     consecutive no-adjust windows needed to assert lock
// PORTS
//  clk4      in   1      clock, 4 x symbol rate
//  reset     in   1      synchronous, active-low
//  en        in   1      advance the timing loop; low = freeze all state
//  x_in      in   DW     oversampled input sample, signed
//  sym_out   out  DW     prompt sample
//  sym_vld   out  1      1-cycle strobe, sym_out valid
//  ted_out   out  ACC_W  accumulator value of the last completed window
//  ted_vld   out  1      1-cycle strobe, ted_out updated
//  phase_adv out  1      1-cycle pulse: one slack slot skipped (period = 3 clk4)
//  phase_ret out  1      1-cycle pulse: slack slot repeated (period = 5 clk4)
//  lock      out  1      timing loop locked
// BEHAVIOUR
//  Reset (reset==0 at a clk4 edge)
//  - All outputs go to 0. Phase counter ph=0; acc, symbol count, pending flags, lock count = 0.
//  - Reset mid-window discards the partial window.
//  Phase schedule (edges where en=1)
//  - ph0 EARLY: e_r <= x_in.
//  - ph1 PROMPT: sym_out <= x_in; sym_vld=1 for exactly this one cycle.
//  - ph2 LATE:
//    - err = sat|e_r| - sat|x_in|, DW+1 bits signed.
//    - sat|-2^(DW-1)| = 2^(DW-1)-1.
//    - acc <= sat(acc + sext(err)); saturates at ACC_W signed limits.
//  - ph3 SLACK: no sample taken.
//  - Normal sequence 0,1,2,3,0...
//  - en=0: ph, registers and pending flags hold. Strobes/pulses are 0 while en=0.
//  Window decision (at the ph2 edge of the NAVG-th symbol), with s = acc+err (saturated):
//  - ted_out <= s; ted_vld=1 for 1 cycle. acc <= 0; symbol count <= 0.
//  - s >  THRESH: adv_pend=1 (early energy higher -> sampling late).
//  - s < -THRESH: ret_pend=1.
//  - Otherwise no pending flag; lock count++, saturating at LOCK_CNT.
//  - Any adjustment clears the lock count and lock.
//  - lock = (lock count == LOCK_CNT); registered, updates the cycle after the decision.
//  Adjustment (applied in the following symbol; samples are never dropped)
//  - adv_pend: at that symbol's ph2 edge, ph <= 0 (skip ph3). Clear adv_pend; phase_adv=1 for 1 cycle.
//  - ret_pend: at that symbol's ph3 edge, ph stays 3 one extra cycle. Clear ret_pend; phase_ret=1.
//  - At most one adjustment per window. adv_pend and ret_pend are never both set.
//  - NAVG>=2 guarantees a pending flag is consumed before the next decision.
//  - The error term for the adjusting symbol is accumulated normally.
// STRUCTURE
//  - Package el_timing_pkg:
//    - phase constants PH_EARLY=0, PH_PROMPT=1, PH_LATE=2, PH_SLACK=3;
//    - saturating abs function;
//    - saturating signed add function.
//  - Sub-module el_ted_accum: err formation, accumulate, window count, threshold decision,
//    ted_out/ted_vld, lock counter.
//  - Top level: phase counter, sample registers, pending flags, adv/ret pulses.
// TESTING
//  1. reset=0 for 2 edges, x_in=7 -> all outputs 0; first sym_vld 2 cycles after reset=1, en=1.
//  2. x_in=1000 constant, en=1 -> err=0; sym_out=1000 every 4 cycles; ted_out=0 every 64 cycles;
//     no adj; lock=1 after 8th window (cycle ~513).
//  3. E=3000, L=1000 at ph0/ph2 -> ted_out=32000; phase_adv once next symbol; that period 3 cycles;
//     lock=0.
//  4. E=-500, L=2500 -> ted_out=-32000; phase_ret once; that period 5 cycles; no sample lost
//     (sym_vld count continuous).
//  5. E=-32768, L=0, NAVG=16 -> err=32767 per symbol; ted_out=524272 (no saturation at ACC_W=24);
//     ACC_W=18 -> ted_out=131071.
//  6. en=0 for 10 cycles mid-window, then reset=0 mid-window -> state frozen during en=0,
//     no strobes; reset clears acc, lock and pending; next ted_out covers a full fresh window.

Source files
------------

// File: rtl/el_timing_pkg.sv
// Shared types and saturating helpers for the early/late timing loop.
// Phase names, saturating |x| and saturating signed add.
package el_timing_pkg;

  typedef enum logic [1:0] {
    PH_EARLY  = 2'd0,
    PH_PROMPT = 2'd1,
    PH_LATE   = 2'd2,
    PH_SLACK  = 2'd3
  } ph_e;

  // |x| for a w-bit signed value; the most negative code maps to max.
  function automatic longint sat_abs(
    input longint x,
    input int     w
  );
    longint mn;
    mn = -(longint'(1) << (w - 1));
    if (x == mn) return -mn - 1;
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint sat_add(
    input longint a,
    input longint b,
    input int     w
  );
    longint mx;
    longint sum;
    mx  = (longint'(1) << (w - 1)) - 1;
    sum = a + b;
    if (sum > mx) return mx;
    if (sum < -mx - 1) return -mx - 1;
    return sum;
  endfunction

endpackage

// File: rtl/el_ted_accum.sv
// Early-late error detector: error, window integration, decision, lock.
// Decisions are combinational so the phase logic can latch them same edge.
module el_ted_accum
  import el_timing_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ACC_W    = 24,
  parameter int NAVG     = 16,
  parameter int THRESH   = 1024,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk4,
  input  logic                    reset,
  input  logic                    late,
  input  logic signed [DW-1:0]    e_r,
  input  logic signed [DW-1:0]    x_in,
  output logic signed [ACC_W-1:0] ted_out,
  output logic                    ted_vld,
  output logic                    dec_adv,
  output logic                    dec_ret,
  output logic                    lock
);

  localparam int CW = (NAVG > 2) ? $clog2(NAVG) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic signed [ACC_W-1:0] TH  = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] NTH = -TH;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s;
  logic        [CW-1:0]    cnt;
  logic        [LW-1:0]    lock_cnt;
  logic        [DW-1:0]    ae;
  logic        [DW-1:0]    al;
  logic signed [DW:0]      err;
  logic                    last;
  logic                    dec;

  assign ae   = DW'(sat_abs(longint'(e_r), DW));
  assign al   = DW'(sat_abs(longint'(x_in), DW));
  assign err  = $signed({1'b0, ae}) - $signed({1'b0, al});
  assign s    = ACC_W'(sat_add(longint'(acc), longint'(err), ACC_W));
  assign last = (cnt == CW'(NAVG - 1));
  assign dec  = late && last;

  assign dec_adv = dec && (s > TH);
  assign dec_ret = dec && (s < NTH);

  always_ff @(posedge clk4) begin
    if (!reset) begin
      acc      <= '0;
      cnt      <= '0;
      ted_out  <= '0;
      ted_vld  <= 1'b0;
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      ted_vld <= 1'b0;
      lock    <= (lock_cnt == LW'(LOCK_CNT));
      if (late) begin
        if (last) begin
          ted_out <= s;
          ted_vld <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
          if (dec_adv || dec_ret)
            lock_cnt <= '0;
          else if (lock_cnt != LW'(LOCK_CNT))
            lock_cnt <= lock_cnt + LW'(1);
        end else begin
          acc <= s;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/el_timing_ctrl.sv
// Early/late symbol timing controller at 4x oversampling.
// Owns the phase counter, sample registers and slip scheduling.
module el_timing_ctrl
  import el_timing_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ACC_W    = 24,
  parameter int NAVG     = 16,
  parameter int THRESH   = 1024,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk4,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [DW-1:0]    x_in,
  output logic signed [DW-1:0]    sym_out,
  output logic                    sym_vld,
  output logic signed [ACC_W-1:0] ted_out,
  output logic                    ted_vld,
  output logic                    phase_adv,
  output logic                    phase_ret,
  output logic                    lock
);

  ph_e                  ph;
  ph_e                  ph_nxt;
  logic signed [DW-1:0] e_r;
  logic                 adv_pend;
  logic                 ret_pend;
  logic                 ret_arm;
  logic                 adv_clr;
  logic                 ret_clr;
  logic                 late;
  logic                 dec_adv;
  logic                 dec_ret;

  assign late = en && (ph == PH_LATE);

  // A retard decided this symbol is armed at the next symbol's late slot.
  always_comb begin
    ph_nxt  = ph;
    adv_clr = 1'b0;
    ret_clr = 1'b0;
    if (en) begin
      unique case (ph)
        PH_EARLY:  ph_nxt = PH_PROMPT;
        PH_PROMPT: ph_nxt = PH_LATE;
        PH_LATE: begin
          if (adv_pend) begin
            ph_nxt  = PH_EARLY;
            adv_clr = 1'b1;
          end else begin
            ph_nxt = PH_SLACK;
          end
        end
        PH_SLACK: begin
          if (ret_arm) begin
            ph_nxt  = PH_SLACK;
            ret_clr = 1'b1;
          end else begin
            ph_nxt = PH_EARLY;
          end
        end
        default: ph_nxt = PH_EARLY;
      endcase
    end
  end

  always_ff @(posedge clk4) begin
    if (!reset) begin
      ph <= PH_EARLY;
    end else begin
      ph <= ph_nxt;
    end
  end

  always_ff @(posedge clk4) begin
    if (!reset) begin
      e_r       <= '0;
      sym_out   <= '0;
      sym_vld   <= 1'b0;
      phase_adv <= 1'b0;
      phase_ret <= 1'b0;
      adv_pend  <= 1'b0;
      ret_pend  <= 1'b0;
      ret_arm   <= 1'b0;
    end else begin
      sym_vld   <= en && (ph == PH_PROMPT);
      phase_adv <= adv_clr;
      phase_ret <= ret_clr;
      if (en && (ph == PH_EARLY))
        e_r <= x_in;
      if (en && (ph == PH_PROMPT))
        sym_out <= x_in;
      if (dec_adv)
        adv_pend <= 1'b1;
      else if (adv_clr)
        adv_pend <= 1'b0;
      if (dec_ret)
        ret_pend <= 1'b1;
      else if (ret_clr)
        ret_pend <= 1'b0;
      if (late && ret_pend)
        ret_arm <= 1'b1;
      else if (ret_clr)
        ret_arm <= 1'b0;
    end
  end

  el_ted_accum #(
    .DW      (DW),
    .ACC_W   (ACC_W),
    .NAVG    (NAVG),
    .THRESH  (THRESH),
    .LOCK_CNT(LOCK_CNT)
  ) u_accum (
    .clk4   (clk4),
    .reset  (reset),
    .late   (late),
    .e_r    (e_r),
    .x_in   (x_in),
    .ted_out(ted_out),
    .ted_vld(ted_vld),
    .dec_adv(dec_adv),
    .dec_ret(dec_ret),
    .lock   (lock)
  );

endmodule

// File: tb/tb_el_timing_ctrl.sv
// Directed bench for el_timing_ctrl: window vectors plus freeze/reset runs.
// A second instance with an 18-bit accumulator covers saturation.
module tb_el_timing_ctrl;

  logic clk4 = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic signed [15:0] x_in = '0;

  logic signed [15:0] sym_out;
  logic               sym_vld;
  logic signed [23:0] ted_out;
  logic               ted_vld;
  logic               phase_adv;
  logic               phase_ret;
  logic               lock;

  logic signed [15:0] sym_out18;
  logic               sym_vld18;
  logic signed [17:0] ted18;
  logic               ted_vld18;
  logic               phase_adv18;
  logic               phase_ret18;
  logic               lock18;

  int checks = 0;
  int errors = 0;
  int bph = 0;

  always #5 clk4 = ~clk4;

  el_timing_ctrl u_dut (
    .clk4     (clk4),
    .reset    (reset),
    .en       (en),
    .x_in     (x_in),
    .sym_out  (sym_out),
    .sym_vld  (sym_vld),
    .ted_out  (ted_out),
    .ted_vld  (ted_vld),
    .phase_adv(phase_adv),
    .phase_ret(phase_ret),
    .lock     (lock)
  );

  el_timing_ctrl #(.ACC_W(18)) u_d18 (
    .clk4     (clk4),
    .reset    (reset),
    .en       (en),
    .x_in     (x_in),
    .sym_out  (sym_out18),
    .sym_vld  (sym_vld18),
    .ted_out  (ted18),
    .ted_vld  (ted_vld18),
    .phase_adv(phase_adv18),
    .phase_ret(phase_ret18),
    .lock     (lock18)
  );

  typedef struct {
    int e;
    int l;
    int p;
    int t24;
    int t18;
    int adv;
    int ret;
    int per;
  } rec_t;

  rec_t recs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit ena, input int ve, input int vp,
                      input int vl);
    int v;
    case (bph)
      0: v = ve;
      1: v = vp;
      2: v = vl;
      default: v = 0;
    endcase
    en   = ena;
    x_in = 16'(v);
    @(posedge clk4);
    #1;
    if (ena) bph = (bph + 1) % 4;
  endtask

  task automatic do_reset(input bit check_zero);
    reset = 1'b0;
    en    = 1'b1;
    x_in  = 16'sd7;
    repeat (2) @(posedge clk4);
    #1;
    if (check_zero) begin
      chk("rst_main", int'({sym_out, sym_vld, ted_out, ted_vld,
                            phase_adv, phase_ret, lock} != 0), 0);
      chk("rst_d18", int'({sym_out18, sym_vld18, ted18, ted_vld18,
                           phase_adv18, phase_ret18, lock18} != 0), 0);
    end
    reset = 1'b1;
    bph   = 0;
  endtask

  task automatic run_rec(input rec_t r, input int idx);
    int t1, t2, nt, nt18, tn, tv, tv18, npa, npr, npa18, npr18;
    t1 = -1; t2 = -1; nt = 0; nt18 = 0; tn = -1; tv = 0; tv18 = 0;
    npa = 0; npr = 0; npa18 = 0; npr18 = 0;
    do_reset(idx == 0);
    for (int n = 1; n <= 95; n++) begin
      step(1'b1, r.e, r.p, r.l);
      if (n == 1)
        chk($sformatf("r%0d_vld_n1", idx), int'(sym_vld), 0);
      if (n == 2) begin
        chk($sformatf("r%0d_vld_n2", idx), int'(sym_vld), 1);
        chk($sformatf("r%0d_sym", idx), int'(sym_out), r.p);
        chk($sformatf("r%0d_sym18", idx), int'(sym_out18), r.p);
      end
      if (ted_vld) begin nt++; tn = n; tv = int'(ted_out); end
      if (ted_vld18) begin nt18++; tv18 = int'(ted18); end
      if (phase_adv) npa++;
      if (phase_ret) npr++;
      if (phase_adv18) npa18++;
      if (phase_ret18) npr18++;
      if (n > 63 && sym_vld) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
    end
    chk($sformatf("r%0d_ted_n", idx), nt, 1);
    chk($sformatf("r%0d_ted_at", idx), tn, 63);
    chk($sformatf("r%0d_ted", idx), tv, r.t24);
    chk($sformatf("r%0d_ted18_n", idx), nt18, 1);
    chk($sformatf("r%0d_ted18", idx), tv18, r.t18);
    chk($sformatf("r%0d_adv", idx), npa, r.adv);
    chk($sformatf("r%0d_ret", idx), npr, r.ret);
    chk($sformatf("r%0d_adv18", idx), npa18, r.adv);
    chk($sformatf("r%0d_ret18", idx), npr18, r.ret);
    chk($sformatf("r%0d_per", idx),
        (t1 > 0 && t2 > 0) ? t2 - t1 : -1, r.per);
    chk($sformatf("r%0d_lock", idx), int'(lock) + int'(lock18), 0);
  endtask

  initial begin
    int nsym, nted, tbad, nadj, frz, tv, nv;

    //          E       L       P     ted24    ted18  adv ret per
    recs[0] = '{1000,   1000,   1234, 0,       0,       0, 0, 4};
    recs[1] = '{3000,   1000,   -77,  32000,   32000,   1, 0, 3};
    recs[2] = '{-500,   2500,   500,  -32000,  -32000,  0, 1, 5};
    recs[3] = '{-32768, 0,      -1,   524272,  131071,  1, 0, 3};
    recs[4] = '{0,      -32768, 32767, -524272, -131072, 0, 1, 5};
    recs[5] = '{1064,   1000,   9,    1024,    1024,    0, 0, 4};
    recs[6] = '{1065,   1000,   -9,   1040,    1040,    1, 0, 3};
    recs[7] = '{1000,   1065,   42,   -1040,   -1040,   0, 1, 5};

    for (int i = 0; i < 8; i++) run_rec(recs[i], i);

    // Constant input: eight clean windows, then lock.
    do_reset(1'b0);
    nsym = 0; nted = 0; tbad = 0; nadj = 0;
    for (int n = 1; n <= 512; n++) begin
      step(1'b1, 1000, 1000, 1000);
      if (sym_vld) nsym++;
      if (ted_vld) begin
        nted++;
        if (ted_out != 0) tbad++;
      end
      if (phase_adv || phase_ret) nadj++;
      if (n == 511) chk("lock_pre", int'(lock), 0);
      if (n == 512) chk("lock_set", int'(lock), 1);
    end
    chk("const_sym_n", nsym, 128);
    chk("const_ted_n", nted, 8);
    chk("const_ted_nz", tbad, 0);
    chk("const_adj", nadj, 0);
    do_reset(1'b1);

    // Freeze mid-window, then reset with an advance pending.
    frz = 0; tv = -1; nv = 0;
    for (int n = 1; n <= 30; n++) step(1'b1, 3000, 5, 1000);
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 32767, 32767, 32767);
      if (sym_vld || ted_vld || phase_adv || phase_ret) frz++;
    end
    chk("frz_strobes", frz, 0);
    chk("frz_ted", int'(ted_out), 0);
    for (int n = 31; n <= 63; n++) begin
      step(1'b1, 3000, 5, 1000);
      if (ted_vld) begin nv++; tv = int'(ted_out); end
    end
    chk("frz_ted_n", nv, 1);
    chk("frz_ted_val", tv, 32000);
    step(1'b1, 3000, 5, 1000);
    do_reset(1'b0);
    nadj = 0; tv = -1;
    for (int n = 1; n <= 80; n++) begin
      step(1'b1, 1000, 1000, 1000);
      if (phase_adv || phase_ret) nadj++;
      if (n == 63) tv = ted_vld ? int'(ted_out) : -1;
    end
    chk("rst_pend_clr", nadj, 0);
    chk("rst_pend_ted", tv, 0);

    // Partial window discarded by reset.
    do_reset(1'b0);
    for (int n = 1; n <= 30; n++) step(1'b1, 3000, 5, 1000);
    do_reset(1'b0);
    tv = -1;
    for (int n = 1; n <= 63; n++) begin
      step(1'b1, 1000, 1000, 1000);
      if (n == 63) tv = ted_vld ? int'(ted_out) : -1;
    end
    chk("rst_acc_clr", tv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
